// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the 5-stage RISC-V core's memory-access stage:
//   - funct3 encodings for loads and stores
//   - MEM-stage FSM state encoding
//   - access_ok(): legality and alignment check for a memory access
// ---------------------------------------------------------------------------
package core_pkg;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DONE     = 2'd2
  } mau_state_t;

  // True when funct3 names a real access of the given direction and the
  // address low bits satisfy that access width's natural alignment.
  function automatic logic access_ok(input logic       is_store,
                                     input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_SB:   ok = 1'b1;
        F3_SH:   ok = ~addr_lo[0];
        F3_SW:   ok = (addr_lo == 2'b00);
        default: ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: ok = 1'b1;
        F3_LH, F3_LHU: ok = ~addr_lo[0];
        F3_LW:         ok = (addr_lo == 2'b00);
        default:       ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/load_formatter.sv
// ---------------------------------------------------------------------------
// load_formatter
// Combinational load-data alignment: picks the byte/halfword lane addressed
// by addr_lo out of the memory word and sign- or zero-extends it.
// Ports:
//   rdata      in  32  word returned by data memory
//   addr_lo    in   2  byte offset of the access within the word
//   funct3     in   3  load width / signedness
//   load_value out 32  value to be written back
// ---------------------------------------------------------------------------
module load_formatter
  import core_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_value
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    lane_b     = rdata[{addr_lo, 3'b000} +: 8];
    lane_h     = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    load_value = rdata;
    case (funct3)
      F3_LB:   load_value = {{24{lane_b[7]}}, lane_b};
      F3_LH:   load_value = {{16{lane_h[15]}}, lane_h};
      F3_LBU:  load_value = {24'h0, lane_b};
      F3_LHU:  load_value = {16'h0, lane_h};
      default: load_value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// MEM stage of the 5-stage RISC-V core. Converts a load or store into one
// req/ack transaction on the data-memory port, stalls the upstream pipeline
// while it is outstanding and sends bubbles toward write-back.
// Ports:
//   clock, reset_n           clock; asynchronous active-low reset
//   in_*                     EX/MEM register contents
//   dmem_req/we/addr/wdata/wstrb   registered request to data memory
//   dmem_ack, dmem_rdata     completion and load word (same cycle)
//   out_mem_read_data        formatted load data (meaningful in DONE)
//   out_alu_result, out_rd, out_memtoreg   pass-through to MEM/WB
//   out_regwrite             write-back enable, suppressed while busy/faulted
//   stall                    freeze PC, IF/ID, ID/EX and EX/MEM
//   misalign_err             one-cycle pulse, misaligned/illegal access
//   bus_err                  one-cycle pulse, access timed out
// ---------------------------------------------------------------------------
module mem_access_unit
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_rd,
  input  logic        in_regwrite,
  input  logic        in_memtoreg,
  input  logic        in_memread,
  input  logic        in_memwrite,
  input  logic [2:0]  in_funct3,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] out_mem_read_data,
  output logic [31:0] out_alu_result,
  output logic [4:0]  out_rd,
  output logic        out_regwrite,
  output logic        out_memtoreg,
  output logic        stall,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mau_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             timeout_q;
  logic [1:0]       addr_lo_q;
  logic [2:0]       funct3_q;
  logic [31:0]      rdata_q;
  logic [31:0]      load_value;

  logic        is_mem;
  logic        op_ok;
  logic        start_op;
  logic        stall_c;
  logic        regwrite_c;
  logic [31:0] store_wdata;
  logic [3:0]  store_wstrb;

  // Any memory intent; both read and write together is an illegal access.
  assign is_mem   = in_valid & (in_memread | in_memwrite);
  assign op_ok    = ~(in_memread & in_memwrite)
                  & access_ok(in_memwrite, in_funct3, in_alu_result[1:0]);
  assign start_op = (state == IDLE) & is_mem & op_ok;

  always_comb begin
    store_wdata = in_store_data;
    store_wstrb = 4'b1111;
    case (in_funct3)
      F3_SB: begin
        store_wdata = {4{in_store_data[7:0]}};
        store_wstrb = 4'b0001 << in_alu_result[1:0];
      end
      F3_SH: begin
        store_wdata = {2{in_store_data[15:0]}};
        store_wstrb = in_alu_result[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_wdata = in_store_data;
        store_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    stall_c    = 1'b0;
    regwrite_c = 1'b0;
    case (state)
      IDLE: begin
        stall_c    = start_op;
        regwrite_c = in_valid & in_regwrite & ~is_mem;
      end
      WAIT_ACK: begin
        stall_c    = 1'b1;
        regwrite_c = 1'b0;
      end
      DONE: begin
        stall_c    = 1'b0;
        regwrite_c = in_valid & in_regwrite & ~timeout_q;
      end
      default: begin
        stall_c    = 1'b0;
        regwrite_c = 1'b0;
      end
    endcase
  end

  // Combinational outputs are forced low while reset is held so a frozen
  // EX/MEM register cannot stall the pipeline during reset.
  assign stall        = reset_n & stall_c;
  assign out_regwrite = reset_n & regwrite_c;
  assign misalign_err = reset_n & (state == IDLE) & is_mem & ~op_ok;
  assign bus_err      = reset_n & (state == DONE) & timeout_q;

  assign out_alu_result    = in_alu_result;
  assign out_rd            = in_rd;
  assign out_memtoreg      = in_memtoreg;
  assign out_mem_read_data = rdata_q;

  load_formatter u_load_formatter (
    .rdata      (dmem_rdata),
    .addr_lo    (addr_lo_q),
    .funct3     (funct3_q),
    .load_value (load_value)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the async reset clears the request at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      timeout_q  <= 1'b0;
      addr_lo_q  <= 2'b00;
      funct3_q   <= 3'b000;
      rdata_q    <= 32'h0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0;
      dmem_wdata <= 32'h0;
      dmem_wstrb <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (start_op) begin
            dmem_req   <= 1'b1;
            dmem_we    <= in_memwrite;
            dmem_addr  <= {in_alu_result[31:2], 2'b00};
            dmem_wdata <= store_wdata;
            dmem_wstrb <= in_memwrite ? store_wstrb : 4'b0000;
            addr_lo_q  <= in_alu_result[1:0];
            funct3_q   <= in_funct3;
            cnt        <= '0;
            timeout_q  <= 1'b0;
            state      <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) rdata_q <= load_value;
            cnt      <= '0;
            state    <= DONE;
          end else if (cnt == CNT_LAST) begin
            dmem_req  <= 1'b0;
            cnt       <= '0;
            timeout_q <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          timeout_q <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Directed self-checking bench for mem_access_unit (TIMEOUT_CYCLES = 4).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;
  import core_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_alu_result;
  logic [31:0] in_store_data;
  logic [4:0]  in_rd;
  logic        in_regwrite, in_memtoreg, in_memread, in_memwrite;
  logic [2:0]  in_funct3;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] out_mem_read_data, out_alu_result;
  logic [4:0]  out_rd;
  logic        out_regwrite, out_memtoreg, stall, misalign_err, bus_err;

  int checks = 0;
  int errors = 0;

  // Results gathered by run_op
  int          r_stalls, r_req, r_bus, r_changes, r_misalign;
  logic        r_done, r_done_rw, r_done_stall;
  logic [31:0] r_done_data, r_addr, r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_we;

  always #5 clock = ~clock;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .in_valid          (in_valid),
    .in_alu_result     (in_alu_result),
    .in_store_data     (in_store_data),
    .in_rd             (in_rd),
    .in_regwrite       (in_regwrite),
    .in_memtoreg       (in_memtoreg),
    .in_memread        (in_memread),
    .in_memwrite       (in_memwrite),
    .in_funct3         (in_funct3),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_wstrb        (dmem_wstrb),
    .dmem_ack          (dmem_ack),
    .dmem_rdata        (dmem_rdata),
    .out_mem_read_data (out_mem_read_data),
    .out_alu_result    (out_alu_result),
    .out_rd            (out_rd),
    .out_regwrite      (out_regwrite),
    .out_memtoreg      (out_memtoreg),
    .stall             (stall),
    .misalign_err      (misalign_err),
    .bus_err           (bus_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_op(input logic [31:0] alu, input logic [31:0] sdata, input logic [4:0] rd,
                        input logic rw, input logic mtr, input logic mr, input logic mw,
                        input logic [2:0] f3);
    in_valid      = 1'b1;
    in_alu_result = alu;
    in_store_data = sdata;
    in_rd         = rd;
    in_regwrite   = rw;
    in_memtoreg   = mtr;
    in_memread    = mr;
    in_memwrite   = mw;
    in_funct3     = f3;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs the op already on the inputs (FSM in IDLE) until its DONE cycle.
  // The memory acks after wait_n request cycles without ack, if give_ack.
  task automatic run_op(input int wait_n, input bit give_ack, input logic [31:0] rdata);
    int waited;
    r_stalls = 0; r_req = 0; r_bus = 0; r_changes = 0; r_misalign = 0;
    r_done = 1'b0; r_done_rw = 1'b0; r_done_stall = 1'b0; r_done_data = 32'h0;
    waited = 0;
    for (int i = 0; i < 40 && !r_done; i++) begin
      @(negedge clock);
      if (stall) r_stalls++;
      if (bus_err) r_bus++;
      if (misalign_err) r_misalign++;
      if (dmem_req) begin
        if (r_req > 0 && {dmem_addr, dmem_wdata, dmem_wstrb, dmem_we} !== {r_addr, r_wdata, r_wstrb, r_we})
          r_changes++;
        r_addr = dmem_addr; r_wdata = dmem_wdata; r_wstrb = dmem_wstrb; r_we = dmem_we;
        r_req++;
        if (give_ack && waited == wait_n) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdata;
        end
        waited++;
      end else if (r_req > 0) begin
        r_done       = 1'b1;
        r_done_rw    = out_regwrite;
        r_done_stall = stall;
        r_done_data  = out_mem_read_data;
      end
      tick();
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
    end
    in_valid = 1'b0;
    check("op_reached_done", {31'b0, r_done}, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    // A load sits on the inputs during reset: stall must stay gated off.
    set_op(32'h0000_0100, 32'h0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, F3_LW);
    @(negedge clock);
    check("rst_req",   {31'b0, dmem_req}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_rw",    {31'b0, out_regwrite}, 32'd0);
    check("rst_rdata", out_mem_read_data, 32'h0);
    check("rst_addr",  dmem_addr, 32'h0);
    check("rst_wstrb", {28'b0, dmem_wstrb}, 32'd0);
    check("rst_errs",  {30'b0, misalign_err, bus_err}, 32'd0);
    in_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // Non-memory op: ADD -> x5 = 0x10
    set_op(32'h0000_0010, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    @(negedge clock);
    check("alu_stall", {31'b0, stall}, 32'd0);
    check("alu_rw",    {31'b0, out_regwrite}, 32'd1);
    check("alu_rd",    {27'b0, out_rd}, 32'd5);
    check("alu_res",   out_alu_result, 32'h0000_0010);
    tick();
    @(negedge clock);
    check("alu_no_req", {31'b0, dmem_req}, 32'd0);
    tick();
    in_valid = 1'b0;

    // LB at 0x103, zero-wait ack, word 0x80FF_0000
    set_op(32'h0000_0103, 32'h0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, F3_LB);
    run_op(0, 1'b1, 32'h80FF_0000);
    check("lb_stalls", r_stalls, 32'd2);
    check("lb_reqcyc", r_req, 32'd1);
    check("lb_addr",   r_addr, 32'h0000_0100);
    check("lb_wstrb",  {28'b0, r_wstrb}, 32'd0);
    check("lb_we",     {31'b0, r_we}, 32'd0);
    check("lb_data",   r_done_data, 32'hFFFF_FF80);
    check("lb_rw",     {31'b0, r_done_rw}, 32'd1);
    check("lb_done_stall", {31'b0, r_done_stall}, 32'd0);

    // SH 0x1234_ABCD at 0x202, ack after 3 wait cycles (also the last
    // counter value before timeout: ack must win)
    set_op(32'h0000_0202, 32'h1234_ABCD, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, F3_SH);
    run_op(3, 1'b1, 32'h0);
    check("sh_stalls", r_stalls, 32'd5);
    check("sh_wstrb",  {28'b0, r_wstrb}, 32'b1100);
    check("sh_wdata",  r_wdata, 32'hABCD_ABCD);
    check("sh_we",     {31'b0, r_we}, 32'd1);
    check("sh_addr",   r_addr, 32'h0000_0200);
    check("sh_stable", r_changes, 32'd0);
    check("sh_no_bus", r_bus, 32'd0);
    check("sh_keeps_rdata", r_done_data, 32'hFFFF_FF80);

    // Misaligned LW at 0x101
    set_op(32'h0000_0101, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, F3_LW);
    @(negedge clock);
    check("mis_err",   {31'b0, misalign_err}, 32'd1);
    check("mis_stall", {31'b0, stall}, 32'd0);
    check("mis_rw",    {31'b0, out_regwrite}, 32'd0);
    tick();
    in_valid = 1'b0;
    @(negedge clock);
    check("mis_once",  {31'b0, misalign_err}, 32'd0);
    check("mis_no_req", {31'b0, dmem_req}, 32'd0);
    tick();

    // Illegal: read and write together; then store with funct3 100
    set_op(32'h0000_0000, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, F3_LW);
    @(negedge clock);
    check("both_err", {31'b0, misalign_err}, 32'd1);
    check("both_rw",  {31'b0, out_regwrite}, 32'd0);
    tick();
    set_op(32'h0000_0000, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100);
    @(negedge clock);
    check("st100_err", {31'b0, misalign_err}, 32'd1);
    check("st100_stall", {31'b0, stall}, 32'd0);
    tick();
    in_valid = 1'b0;
    @(negedge clock);
    check("ill_no_req", {31'b0, dmem_req}, 32'd0);
    tick();

    // LW at 0x300, memory never acks: timeout after 4 request cycles
    set_op(32'h0000_0300, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, F3_LW);
    run_op(0, 1'b0, 32'h0);
    check("to_reqcyc", r_req, 32'd4);
    check("to_bus",    r_bus, 32'd1);
    check("to_rw",     {31'b0, r_done_rw}, 32'd0);
    check("to_rdata_kept", r_done_data, 32'hFFFF_FF80);
    @(negedge clock);
    check("to_bus_clear", {31'b0, bus_err}, 32'd0);
    tick();

    // Load formatting cases (back in IDLE after timeout)
    set_op(32'h0000_0101, 32'h0, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, F3_LBU);
    run_op(0, 1'b1, 32'h0000_8000);
    check("lbu_data", r_done_data, 32'h0000_0080);
    check("lbu_addr", r_addr, 32'h0000_0100);

    set_op(32'h0000_0102, 32'h0, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, F3_LHU);
    run_op(1, 1'b1, 32'hF00D_1234);
    check("lhu_data",   r_done_data, 32'h0000_F00D);
    check("lhu_stalls", r_stalls, 32'd3);

    set_op(32'h0000_0002, 32'h0, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, F3_LH);
    run_op(0, 1'b1, 32'h8001_0000);
    check("lh_data", r_done_data, 32'hFFFF_8001);

    set_op(32'h0000_0020, 32'h0, 5'd13, 1'b1, 1'b1, 1'b1, 1'b0, F3_LW);
    run_op(2, 1'b1, 32'h1357_9BDF);
    check("lw_data",   r_done_data, 32'h1357_9BDF);
    check("lw_reqcyc", r_req, 32'd3);

    // Store formatting cases
    set_op(32'h0000_0003, 32'h0000_00A5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, F3_SB);
    run_op(0, 1'b1, 32'h0);
    check("sb_wdata", r_wdata, 32'hA5A5_A5A5);
    check("sb_wstrb", {28'b0, r_wstrb}, 32'b1000);
    check("sb_addr",  r_addr, 32'h0000_0000);

    set_op(32'h0000_0010, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, F3_SW);
    run_op(0, 1'b1, 32'h0);
    check("sw_wdata", r_wdata, 32'hDEAD_BEEF);
    check("sw_wstrb", {28'b0, r_wstrb}, 32'b1111);

    // Reset during WAIT_ACK, then a late ack
    set_op(32'h0000_0040, 32'h0, 5'd14, 1'b1, 1'b1, 1'b1, 1'b0, F3_LW);
    tick();
    @(negedge clock);
    check("rm_req_up", {31'b0, dmem_req}, 32'd1);
    tick();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rm_req_drop", {31'b0, dmem_req}, 32'd0);
    check("rm_stall",    {31'b0, stall}, 32'd0);
    @(negedge clock);
    reset_n    = 1'b1;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    tick();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    @(negedge clock);
    check("rm_ack_ignored", {31'b0, dmem_req}, 32'd0);
    check("rm_rdata",       out_mem_read_data, 32'h0);
    check("rm_no_err",      {30'b0, bus_err, stall}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
